// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared types and constants for the MEM-stage data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

    localparam int DEFAULT_WORD_LENGTH   = 16;
    localparam int DEFAULT_ADDRESS_SPACE = 12;
    localparam int DEPTH                 = 2 ** DEFAULT_ADDRESS_SPACE;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WIDE2 = 2'd2
    } state_t;

    // Response record at the default geometry; the response pipe carries the
    // same fields sized by its DATA_W parameter.
    typedef struct packed {
        logic                             valid;
        logic                             err;
        logic [2*DEFAULT_WORD_LENGTH-1:0] data;
    } rsp_rec_t;

    function automatic int depth_of(input int addr_bits);
        return 2 ** addr_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_rsp_pipe.sv
// ============================================================================
// Module   : mem_rsp_pipe
// Brief    : Fixed-latency shift register of response records, flushed on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rsp_pipe #(
    parameter int LATENCY = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rec_t;

    rec_t r_stage [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0].valid <= i_valid;
            r_stage[0].err   <= i_err;
            r_stage[0].data  <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[LATENCY-1].valid;
    assign o_err   = r_stage[LATENCY-1].err;
    assign o_data  = r_stage[LATENCY-1].data;

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : MEM-stage data memory with word/double-word access, clearing
//            sweep after reset and a programmable response latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WIDE_EN       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic                       req_wide,
    input  logic [ADDRESS_SPACE-1:0]   req_addr,
    input  logic [2*WORD_LENGTH-1:0]   req_wdata,
    output logic                       rsp_valid,
    output logic [2*WORD_LENGTH-1:0]   rsp_rdata,
    output logic                       rsp_err
);

    localparam int                       c_depth    = depth_of(ADDRESS_SPACE);
    localparam logic [ADDRESS_SPACE-1:0] c_top_addr = {ADDRESS_SPACE{1'b1}};
    localparam logic [ADDRESS_SPACE-1:0] c_addr_one = {{(ADDRESS_SPACE-1){1'b0}}, 1'b1};

    logic [WORD_LENGTH-1:0]   r_mem [c_depth];

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_SPACE-1:0] r_clr_cnt;
    logic [ADDRESS_SPACE-1:0] r_addr_p1;
    logic                     r_we_wide;
    logic [WORD_LENGTH-1:0]   r_lo_wdata;
    logic [WORD_LENGTH-1:0]   r_hi_rdata;

    logic                     w_wide_err;
    logic                     w_wide_start;
    logic                     w_mem_we;
    logic [ADDRESS_SPACE-1:0] w_mem_addr;
    logic [WORD_LENGTH-1:0]   w_mem_wdata;
    logic [ADDRESS_SPACE-1:0] w_rd_addr;
    logic [WORD_LENGTH-1:0]   w_rd_word;
    logic                     w_pipe_valid;
    logic                     w_pipe_err;
    logic [2*WORD_LENGTH-1:0] w_pipe_data;

    assign req_ready  = (r_state == ST_IDLE);
    // The top address has no partner word; wide accesses never wrap to 0.
    assign w_wide_err = req_wide && ((WIDE_EN == 0) || (req_addr == c_top_addr));
    assign w_rd_addr  = (r_state == ST_WIDE2) ? r_addr_p1 : req_addr;
    assign w_rd_word  = r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt  = r_state;
        w_wide_start = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = req_addr;
        w_mem_wdata  = '0;
        w_pipe_valid = 1'b0;
        w_pipe_err   = 1'b0;
        w_pipe_data  = '0;
        case (r_state)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
                if (r_clr_cnt == c_top_addr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_wide_err) begin
                        w_pipe_valid = 1'b1;
                        w_pipe_err   = 1'b1;
                    end else if (req_wide) begin
                        // High half first; its response is issued from WIDE2.
                        w_mem_we     = req_we;
                        w_mem_wdata  = req_wdata[2*WORD_LENGTH-1:WORD_LENGTH];
                        w_wide_start = 1'b1;
                        w_state_nxt  = ST_WIDE2;
                    end else begin
                        w_mem_we     = req_we;
                        w_mem_wdata  = req_wdata[WORD_LENGTH-1:0];
                        w_pipe_valid = 1'b1;
                        w_pipe_data  = req_we ? '0 : {{WORD_LENGTH{1'b0}}, w_rd_word};
                    end
                end
            end
            ST_WIDE2: begin
                w_mem_we     = r_we_wide;
                w_mem_addr   = r_addr_p1;
                w_mem_wdata  = r_lo_wdata;
                w_pipe_valid = 1'b1;
                w_pipe_data  = r_we_wide ? '0 : {r_hi_rdata, w_rd_word};
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_clr_cnt  <= '0;
            r_addr_p1  <= '0;
            r_we_wide  <= 1'b0;
            r_lo_wdata <= '0;
            r_hi_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_clr_cnt <= r_clr_cnt + c_addr_one;
            end
            if (w_wide_start) begin
                r_addr_p1  <= req_addr + c_addr_one;
                r_we_wide  <= req_we;
                r_lo_wdata <= req_wdata[WORD_LENGTH-1:0];
                r_hi_rdata <= w_rd_word;
            end
        end
    end

    // Array carries no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    mem_rsp_pipe #(
        .LATENCY (READ_LATENCY),
        .DATA_W  (2*WORD_LENGTH)
    ) u_rsp_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_pipe_valid),
        .i_err   (w_pipe_err),
        .i_data  (w_pipe_data),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_data  (rsp_rdata)
    );

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the pipeline's MEM stage, with a registered request/response handshake and separate read and write data buses in place of a bidirectional data bus. It supports single-word and double-word ("wide") accesses; wide accesses carry 32-bit PC/flags values for CALL/RET/INT on the 16-bit datapath. A programmable read-latency pipeline and a post-reset clearing sweep replace single-cycle bulk clearing. The block sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- WORD_LENGTH, 16, bits per memory word
- ADDRESS_SPACE, 12, address bits; depth = 2**ADDRESS_SPACE words
- READ_LATENCY, 2, cycles from final array access to response; legal range 1..4
- WIDE_EN, 1, 1 enables double-word accesses; 0 makes every wide request an error

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_wide  in  1  1 = double-word access at addr and addr+1
- req_addr  in  ADDRESS_SPACE  word address
- req_wdata  in  2*WORD_LENGTH  write data; word mode uses the low half
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  2*WORD_LENGTH  read data; word reads are zero-extended; 0 for writes and errors
- rsp_err  out  1  qualified by rsp_valid; the access was rejected

## Operation
- FSM states are INIT, IDLE and WIDE2.
- req_ready = (state == IDLE). req_ready never depends on req_valid.
- INIT:
  - Entered on reset.
  - A clear counter sweeps from 0 to 2**ADDRESS_SPACE-1, writing 0 to one word per cycle.
  - Moves to IDLE after the last word is written.
- IDLE, when a request is accepted (req_valid && req_ready):
  - Word access: writes set mem[addr] = wdata[W-1:0]. Reads capture mem[addr]. The FSM stays in IDLE.
  - Wide access: the first array cycle handles the high half. Writes set mem[addr] = wdata[2W-1:W]; reads capture mem[addr] into the high half. The FSM then goes to WIDE2.
  - A wide request is an error if WIDE_EN==0 or addr == 2**ADDRESS_SPACE-1.
  - An error request does not touch the array, does not enter WIDE2, and returns rsp_err=1 with rdata 0. There is no wrap to address 0.
- WIDE2:
  - Handles the low half at the latched addr+1 (write or read).
  - Returns to IDLE unconditionally.
  - The request bus is ignored in this state.
- Ordering and hazards:
  - Every accepted request (read, write or error) produces exactly one response, in acceptance order.
  - A write updates the array at the edge that completes its access, so a read accepted in the following cycle returns the new data. No forwarding logic is required.
- Reset mid-operation: the in-flight WIDE2 and all pending responses are discarded, the FSM returns to INIT, and the sweep restarts from 0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. The clear counter is 0.
- Sweep length: req_ready rises exactly 2**ADDRESS_SPACE cycles after the first cycle with reset low.
- Word request accepted in cycle k: rsp_valid is high in cycle k+READ_LATENCY.
- Wide request accepted in cycle k:
  - req_ready is low in cycle k+1.
  - rsp_valid is high in cycle k+1+READ_LATENCY.
- Error request accepted in cycle k: rsp_valid is high in cycle k+READ_LATENCY.
- Throughput:
  - Word accesses: one per cycle.
  - Wide accesses: one per two cycles.
- Every response output (rsp_valid, rsp_rdata, rsp_err) is registered and is a one-cycle strobe.

## Structure
- Shared package data_mem_pkg holds:
  - the state typedef (INIT, IDLE, WIDE2)
  - localparam DEPTH = 2**ADDRESS_SPACE
  - the response-record typedef (valid, err, data)
- Sub-module mem_rsp_pipe:
  - A READ_LATENCY-deep shift register of response records with a synchronous flush on reset.
  - The top level handles the FSM, the clear counter and the array.

## Test plan
- Reset held 3 cycles, then released with ADDRESS_SPACE=4 → req_ready=0 for exactly 16 cycles. Reading every address afterward returns 0.
- Word write at addr 5 with data 0xBEEF, then a word read at addr 5 in the next cycle, READ_LATENCY=2 → read response in the acceptance cycle+2 with rsp_rdata=0x0000BEEF and rsp_err=0.
- Wide write at addr 8 with data 0x1234ABCD, then a word read at addr 8 and a word read at addr 9 → 0x1234 and 0xABCD. req_ready is low for the one cycle after the wide accept.
- Wide read at the top address (ADDRESS_SPACE=4, addr 15) → rsp_err=1 and rsp_rdata=0, with memory unchanged. Repeating the request with WIDE_EN=0 at addr 2 also gives rsp_err=1.
- Back-to-back word reads at addrs 0..7 issued every cycle → eight consecutive rsp_valid pulses with data in order and no gaps.
- Reset asserted during WIDE2 with two reads pending → no rsp_valid after the reset edge, the sweep restarts, and the high half already written is cleared to 0.
